hdmi_mid_filter_3x3: RTL and testbench

HDMI_MID_FILTER_3X3 -- requirements
Module: hdmi_mid_filter_3x3

---
 rtl/hdmi_mid_filter_pkg.sv | 13 +
 rtl/sort3.sv | 32 +++
 rtl/hdmi_mid_filter_3x3.sv | 205 ++++++++++++++++++++
 tb/tb_hdmi_mid_filter_3x3.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/hdmi_mid_filter_pkg.sv
// Shared constants and the pixel type for the 3x3 median filter.
package hdmi_mid_filter_pkg;
    localparam int LAT      = 32'sd4;
    localparam int N_CH     = 32'sd3;
    localparam int WIN_N    = 32'sd3;
    localparam int WIN_TOP  = 32'sd0;
    localparam int WIN_MID  = 32'sd1;
    localparam int WIN_BOT  = 32'sd2;
    localparam int ROW_BITS = 32'sd11;
    localparam logic [ROW_BITS-1:0] ROW_MAX = 11'd2047;

    typedef logic [23:0] pixel_t;
endpackage

// File: rtl/sort3.sv
// Three-input compare network returning minimum, median and maximum.
module sort3 #(
    parameter int W = 32'sd8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] c,
    output logic [W-1:0] mn,
    output logic [W-1:0] md,
    output logic [W-1:0] mx
);
    logic [W-1:0] lo_s;
    logic [W-1:0] hi_s;
    logic [W-1:0] hc_s;

    // Order (a,b) first, then slot c against both ends.
    always_comb begin
        lo_s = a;
        hi_s = b;
        if (b < a) begin
            lo_s = b;
            hi_s = a;
        end else begin
            lo_s = a;
            hi_s = b;
        end
        hc_s = (c < hi_s) ? c : hi_s;
        mn   = (c < lo_s) ? c : lo_s;
        mx   = (c > hi_s) ? c : hi_s;
        md   = (hc_s > lo_s) ? hc_s : lo_s;
    end
endmodule

// File: rtl/hdmi_mid_filter_3x3.sv
// 3x3 per-channel median filter on the HDMI pixel stream, fixed latency LAT.
// Defining MID_FILTER_BYPASS_EN adds filter_en, latched once per frame on vs_in rise.
module hdmi_mid_filter_3x3
    import hdmi_mid_filter_pkg::*;
#(
    parameter int H_ACT       = 32'sd1920,
    parameter int COLOR_DEPTH = 32'sd8,
    parameter int X_BITS      = 32'sd12
) (
    input  logic                       pix_clk,
    input  logic                       rst,
`ifdef MID_FILTER_BYPASS_EN
    input  logic                       filter_en,
`endif
    input  logic                       vs_in,
    input  logic                       hs_in,
    input  logic                       de_in,
    input  logic [3*COLOR_DEPTH-1:0]   pixel_in,
    output logic                       vs_out,
    output logic                       hs_out,
    output logic                       de_out,
    output logic [3*COLOR_DEPTH-1:0]   pixel_out
);
    localparam int CD    = COLOR_DEPTH;
    localparam int PIX_W = 3 * COLOR_DEPTH;
    localparam int AW    = $clog2(H_ACT);
    localparam logic [X_BITS-1:0] COL_MAX = X_BITS'(H_ACT - 32'sd1);

    logic [X_BITS-1:0]   col_cnt_r;
    logic                col_full_r;
    logic [ROW_BITS-1:0] row_cnt_r;
    logic                vs_prev_r;
    logic                de_prev_r;
    logic                frame_ok_r;
    logic                mode_r;

    logic [PIX_W-1:0] lb0_r [H_ACT];
    logic [PIX_W-1:0] lb1_r [H_ACT];
    logic [PIX_W-1:0] win_r [WIN_N][WIN_N];
    logic [AW-1:0]    addr_s;
    logic             wr_en_s;
    logic             pass_s;

    logic [2:0]       tim_r  [LAT];
    logic [2:0]       pass_r;
    logic [PIX_W-1:0] raw_r  [3];

    logic [CD-1:0] s1_mn_s [N_CH][WIN_N];
    logic [CD-1:0] s1_md_s [N_CH][WIN_N];
    logic [CD-1:0] s1_mx_s [N_CH][WIN_N];
    logic [CD-1:0] s1_mn_r [N_CH][WIN_N];
    logic [CD-1:0] s1_md_r [N_CH][WIN_N];
    logic [CD-1:0] s1_mx_r [N_CH][WIN_N];
    logic [CD-1:0] s2_lo_s [N_CH];
    logic [CD-1:0] s2_md_s [N_CH];
    logic [CD-1:0] s2_hi_s [N_CH];
    logic [CD-1:0] s2_lo_r [N_CH];
    logic [CD-1:0] s2_md_r [N_CH];
    logic [CD-1:0] s2_hi_r [N_CH];
    logic [CD-1:0] med_s   [N_CH];
    logic [CD-1:0] s2_unused_a_s [N_CH][4];
    logic [CD-1:0] s3_unused_a_s [N_CH][2];

    assign addr_s  = col_cnt_r[AW-1:0];
    assign wr_en_s = de_in & ~col_full_r;

    // Window incomplete near the top/left edge, before the first frame start, or in bypass mode.
    always_comb begin
        pass_s = 1'b0;
        if ((col_cnt_r < X_BITS'(WIN_BOT)) || (row_cnt_r < ROW_BITS'(WIN_BOT)) ||
            !frame_ok_r || !mode_r) begin
            pass_s = 1'b1;
        end else begin
            pass_s = 1'b0;
        end
    end

    // Column/row position tracking and per-frame mode latch.
    always_ff @(posedge pix_clk) begin
        if (rst) begin
            col_cnt_r  <= '0;
            col_full_r <= 1'b0;
            row_cnt_r  <= '0;
            vs_prev_r  <= 1'b0;
            de_prev_r  <= 1'b0;
            frame_ok_r <= 1'b0;
            mode_r     <= 1'b0;
        end else begin
            vs_prev_r <= vs_in;
            de_prev_r <= de_in;
            if (vs_in && !vs_prev_r) begin
                row_cnt_r  <= '0;
                frame_ok_r <= 1'b1;
`ifdef MID_FILTER_BYPASS_EN
                mode_r     <= filter_en;
`else
                mode_r     <= 1'b1;
`endif
            end else if (!de_in && de_prev_r && (row_cnt_r != ROW_MAX)) begin
                row_cnt_r <= row_cnt_r + ROW_BITS'(1'b1);
            end
            if (de_in) begin
                if (col_cnt_r != COL_MAX) begin
                    col_cnt_r <= col_cnt_r + X_BITS'(1'b1);
                end else begin
                    col_full_r <= 1'b1;
                end
            end else begin
                col_cnt_r  <= '0;
                col_full_r <= 1'b0;
            end
        end
    end

    // Line buffers cascade: lb0 holds the previous line, lb1 the one before it.
    always_ff @(posedge pix_clk) begin
        if (wr_en_s) begin
            lb0_r[addr_s] <= pixel_in;
            lb1_r[addr_s] <= lb0_r[addr_s];
        end
    end

    // Window shift: newest column enters at index WIN_N-1 with the live pixel at the bottom.
    always_ff @(posedge pix_clk) begin
        if (rst) begin
            win_r <= '{default: '0};
        end else if (de_in) begin
            for (int c = 32'sd0; c < WIN_N - 32'sd1; c++) begin
                win_r[c] <= win_r[c + 32'sd1];
            end
            win_r[WIN_N-1][WIN_TOP] <= lb1_r[addr_s];
            win_r[WIN_N-1][WIN_MID] <= lb0_r[addr_s];
            win_r[WIN_N-1][WIN_BOT] <= pixel_in;
        end
    end

    for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch
        for (genvar c = 0; c < WIN_N; c++) begin : g_col
            sort3 #(.W(CD)) u_col_sort (
                .a  (win_r[c][WIN_TOP][ch*CD +: CD]),
                .b  (win_r[c][WIN_MID][ch*CD +: CD]),
                .c  (win_r[c][WIN_BOT][ch*CD +: CD]),
                .mn (s1_mn_s[ch][c]),
                .md (s1_md_s[ch][c]),
                .mx (s1_mx_s[ch][c])
            );
        end
        sort3 #(.W(CD)) u_mins (
            .a (s1_mn_r[ch][0]), .b (s1_mn_r[ch][1]), .c (s1_mn_r[ch][2]),
            .mn (s2_unused_a_s[ch][0]), .md (s2_unused_a_s[ch][1]), .mx (s2_lo_s[ch])
        );
        sort3 #(.W(CD)) u_meds (
            .a (s1_md_r[ch][0]), .b (s1_md_r[ch][1]), .c (s1_md_r[ch][2]),
            .mn (s2_unused_a_s[ch][2]), .md (s2_md_s[ch]), .mx (s2_unused_a_s[ch][3])
        );
        sort3 #(.W(CD)) u_maxs (
            .a (s1_mx_r[ch][0]), .b (s1_mx_r[ch][1]), .c (s1_mx_r[ch][2]),
            .mn (s2_hi_s[ch]), .md (s3_unused_a_s[ch][0]), .mx (s3_unused_a_s[ch][1])
        );
        sort3 #(.W(CD)) u_final (
            .a (s2_lo_r[ch]), .b (s2_md_r[ch]), .c (s2_hi_r[ch]),
            .mn (), .md (med_s[ch]), .mx ()
        );
    end

    // Median pipeline, timing delay line and final output select.
    always_ff @(posedge pix_clk) begin
        if (rst) begin
            s1_mn_r   <= '{default: '0};
            s1_md_r   <= '{default: '0};
            s1_mx_r   <= '{default: '0};
            s2_lo_r   <= '{default: '0};
            s2_md_r   <= '{default: '0};
            s2_hi_r   <= '{default: '0};
            tim_r     <= '{default: '0};
            raw_r     <= '{default: '0};
            pass_r    <= '0;
            pixel_out <= '0;
        end else begin
            s1_mn_r  <= s1_mn_s;
            s1_md_r  <= s1_md_s;
            s1_mx_r  <= s1_mx_s;
            s2_lo_r  <= s2_lo_s;
            s2_md_r  <= s2_md_s;
            s2_hi_r  <= s2_hi_s;
            tim_r[0] <= {vs_in, hs_in, de_in};
            for (int i = 32'sd1; i < LAT; i++) begin
                tim_r[i] <= tim_r[i - 32'sd1];
            end
            raw_r[0] <= pixel_in;
            raw_r[1] <= raw_r[0];
            raw_r[2] <= raw_r[1];
            pass_r   <= {pass_r[1:0], pass_s};
            if (!tim_r[LAT-2][0]) begin
                pixel_out <= '0;
            end else if (pass_r[2]) begin
                pixel_out <= raw_r[2];
            end else begin
                pixel_out <= {med_s[2], med_s[1], med_s[0]};
            end
        end
    end

    assign {vs_out, hs_out, de_out} = tim_r[LAT-1];
endmodule

// File: tb/tb_hdmi_mid_filter_3x3.sv
// Directed bench for hdmi_mid_filter_3x3 on a reduced 16-pixel-wide raster.
module tb_hdmi_mid_filter_3x3;
    import hdmi_mid_filter_pkg::*;

    localparam int H      = 16;
    localparam int HB     = 4;
    localparam int LINE_T = H + HB;
    localparam int ROWS   = 6;

    logic   pix_clk = 1'b0;
    logic   rst = 1'b1;
    logic   vs_in = 1'b0, hs_in = 1'b0, de_in = 1'b0;
    pixel_t pixel_in = 24'h000000;
    logic   vs_out, hs_out, de_out;
    pixel_t pixel_out;
`ifdef MID_FILTER_BYPASS_EN
    logic   filter_en = 1'b1;
`endif

    int n_vec = 0;
    int n_fail = 0;

    // capture state, written only by the negedge monitor
    pixel_t out_pix [8][24];
    int     o_row = 0, o_col = 0, n_de_out = 0, n_blank_nz = 0, ncyc = 0;
    int     t_de_in = 0, t_de_out = 0, t_hs_in = 0, t_hs_out = 0, t_vs_in = 0, t_vs_out = 0;
    logic   cap_clr = 1'b0;
    logic   de_in_q = 1'b0, hs_in_q = 1'b0, vs_in_q = 1'b0;
    logic   de_out_q = 1'b0, hs_out_q = 1'b0, vs_out_q = 1'b0;

    hdmi_mid_filter_3x3 #(.H_ACT(H), .COLOR_DEPTH(8), .X_BITS(12)) dut (
        .pix_clk   (pix_clk),
        .rst       (rst),
`ifdef MID_FILTER_BYPASS_EN
        .filter_en (filter_en),
`endif
        .vs_in     (vs_in),
        .hs_in     (hs_in),
        .de_in     (de_in),
        .pixel_in  (pixel_in),
        .vs_out    (vs_out),
        .hs_out    (hs_out),
        .de_out    (de_out),
        .pixel_out (pixel_out)
    );

    always #5 pix_clk = ~pix_clk;

    always @(negedge pix_clk) begin
        ncyc     <= ncyc + 1;
        de_in_q  <= de_in;
        hs_in_q  <= hs_in;
        vs_in_q  <= vs_in;
        de_out_q <= de_out;
        hs_out_q <= hs_out;
        vs_out_q <= vs_out;
        if (de_in && !de_in_q)   t_de_in  <= ncyc;
        if (de_out && !de_out_q) t_de_out <= ncyc;
        if (!hs_in && hs_in_q)   t_hs_in  <= ncyc;
        if (!hs_out && hs_out_q) t_hs_out <= ncyc;
        if (vs_in && !vs_in_q)   t_vs_in  <= ncyc;
        if (vs_out && !vs_out_q) t_vs_out <= ncyc;
        if (cap_clr) begin
            o_row      <= 0;
            o_col      <= 0;
            n_de_out   <= 0;
            n_blank_nz <= 0;
            for (int r = 0; r < 8; r++)
                for (int c = 0; c < 24; c++)
                    out_pix[r][c] <= {24{1'bx}};
        end else begin
            if (!de_out && (pixel_out !== 24'h000000)) n_blank_nz <= n_blank_nz + 1;
            if (vs_out && !vs_out_q) begin
                o_row <= 0;
                o_col <= 0;
            end else if (de_out) begin
                if (o_row < 8 && o_col < 24) out_pix[o_row][o_col] <= pixel_out;
                o_col    <= o_col + 1;
                n_de_out <= n_de_out + 1;
            end else begin
                if (de_out_q) o_row <= o_row + 1;
                o_col <= 0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic vs, input logic hs, input logic de, input pixel_t px);
        vs_in    = vs;
        hs_in    = hs;
        de_in    = de;
        pixel_in = px;
        @(posedge pix_clk);
        #1;
    endtask

    task automatic cap_clear();
        cap_clr = 1'b1;
        @(posedge pix_clk);
        #1;
        cap_clr = 1'b0;
    endtask

    function automatic pixel_t pat(input int kind, input int r, input int c);
        case (kind)
            0: return 24'h404040;
            1: return (r == 3 && c == 3) ? 24'hFFFFFF : 24'h000000;
            2: return (c >= H / 2) ? 24'hFFFFFF : 24'h000000;
            default: return 24'h000000;
        endcase
    endfunction

    // hand-derived expectations: impulse is removed, the black/white edge moves one column right
    function automatic pixel_t expect_pix(input int kind, input bit thru, input int r, input int c);
        case (kind)
            0: return 24'h404040;
            1: return thru ? pat(1, r, c) : 24'h000000;
            2: return (thru || r < 2) ? pat(2, r, c) :
                      ((c >= H / 2 + 1) ? 24'hFFFFFF : 24'h000000);
            default: return 24'h000000;
        endcase
    endfunction

    task automatic run_frame(input int kind, input bit with_vs);
        for (int i = 0; i < LINE_T; i++) drive(with_vs, 1'b0, 1'b0, 24'h000000);
        for (int r = 0; r < ROWS; r++) begin
            for (int i = 0; i < HB; i++) drive(1'b0, i < 2, 1'b0, 24'h000000);
            for (int c = 0; c < H; c++) drive(1'b0, 1'b0, 1'b1, pat(kind, r, c));
        end
        for (int i = 0; i < 8; i++) drive(1'b0, 1'b0, 1'b0, 24'h000000);
    endtask

    task automatic check_frame(input int kind, input bit thru, input string tag);
        check({tag, " de_out count"}, n_de_out, ROWS * H);
        check({tag, " blank nonzero"}, n_blank_nz, 0);
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < H; c++)
                check($sformatf("%s r%0d c%0d", tag, r, c), {8'h00, out_pix[r][c]},
                      {8'h00, expect_pix(kind, thru, r, c)});
    endtask

    initial begin
        @(posedge pix_clk);
        #1;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b0, 24'h000000);
        check("reset vs_out", vs_out, 1'b0);
        check("reset hs_out", hs_out, 1'b0);
        check("reset de_out", de_out, 1'b0);
        check("reset pixel_out", pixel_out, 24'h000000);
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 24'h000000);

        cap_clear();
        run_frame(0, 1'b1);
        check_frame(0, 1'b0, "const");
        check("de latency", t_de_out - t_de_in, 4);
        check("hs latency", t_hs_out - t_hs_in, 4);
        check("vs latency", t_vs_out - t_vs_in, 4);

        cap_clear();
        run_frame(1, 1'b1);
        check_frame(1, 1'b0, "impulse");

        cap_clear();
        run_frame(2, 1'b1);
        check_frame(2, 1'b0, "halves");

        // reset in the white half of a line, then pass-through until the next vs_in
        for (int i = 0; i < LINE_T; i++) drive(1'b1, 1'b0, 1'b0, 24'h000000);
        for (int c = 0; c < H; c++) drive(1'b0, 1'b0, 1'b1, pat(2, 0, c));
        for (int i = 0; i < HB; i++) drive(1'b0, i < 2, 1'b0, 24'h000000);
        for (int c = 0; c < 12; c++) drive(1'b0, 1'b0, 1'b1, pat(2, 1, c));
        check("pre-reset de_out", de_out, 1'b1);
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 1'b0, 1'b1, pat(2, 1, 12 + k));
            check($sformatf("midline reset de_out %0d", k), de_out, 1'b0);
            check($sformatf("midline reset pixel_out %0d", k), pixel_out, 24'h000000);
            check($sformatf("midline reset hs_out %0d", k), hs_out, 1'b0);
            check($sformatf("midline reset vs_out %0d", k), vs_out, 1'b0);
        end
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b1, pat(2, 1, 15));
        for (int i = 0; i < 8; i++) drive(1'b0, 1'b0, 1'b0, 24'h000000);

        cap_clear();
        run_frame(2, 1'b0);
        check_frame(2, 1'b1, "post-reset passthru");

        cap_clear();
        run_frame(2, 1'b1);
        check_frame(2, 1'b0, "post-reset filtered");

`ifdef MID_FILTER_BYPASS_EN
        filter_en = 1'b0;
        cap_clear();
        fork
            run_frame(1, 1'b1);
            begin
                repeat (LINE_T * 2) @(posedge pix_clk);
                #1;
                filter_en = 1'b1;
            end
        join
        check_frame(1, 1'b1, "bypass impulse");

        cap_clear();
        run_frame(1, 1'b1);
        check_frame(1, 1'b0, "bypass next frame");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
